// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: default counter sizing
// and the measurement state encoding.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF   = 11;
    localparam int unsigned TIMEOUT_DEF = 2000;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, followed by a delay
// flop so single-cycle rise/fall strobes can be derived in the clk domain.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign s    = sync_q;
    assign rise =  sync_q & ~dly_q;
    assign fall = ~sync_q &  dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM signal once per period,
// and reports a line that has stopped toggling as stuck high or stuck low.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic s, rise, fall;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (pwm_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q, stuck_low_d;
    logic             timeout;
    logic             restart;

    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        hi_lat_d     = hi_lat_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        meas_valid_d = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        timeout = (run_cnt_q == TIMEOUT_C);
        // run_cnt spans a whole period in HIGH/LOW; only WAIT restarts on a fall
        restart = rise | ((state_q == ST_WAIT) & fall);

        if (restart) begin
            run_cnt_d = CNT_ONE;
        end else if (run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        if (timeout) begin
            state_d      = ST_WAIT;
            stuck_high_d = s;
            stuck_low_d  = ~s;
            high_cnt_d   = '0;
            period_cnt_d = '0;
            meas_valid_d = s ? ~stuck_high_q : ~stuck_low_q;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (rise) state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    if (fall) begin
                        hi_lat_d = run_cnt_q;
                        state_d  = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_cnt_d = run_cnt_q;
                        high_cnt_d   = hi_lat_q;
                        meas_valid_d = 1'b1;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                        state_d      = ST_HIGH;
                    end
                end
                default: state_d = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT;
            run_cnt_q    <= '0;
            hi_lat_q     <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            hi_lat_q     <= hi_lat_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            meas_valid_q <= meas_valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign meas_valid = meas_valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a behavioural PWM source driven from a
// linear stimulus sequence, with expected counts worked out by hand.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in;
    logic [10:0] high_cnt;
    logic [10:0] period_cnt;
    logic        meas_valid;
    logic        stuck_high;
    logic        stuck_low;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt = 0;
    int n_rise = 0;
    int vstart;
    int d;

    // PWM source; new period/duty take effect only at a period boundary
    int unsigned cfg_period = 1024;
    int unsigned cfg_duty   = 300;
    int unsigned act_period = 1024;
    int unsigned act_duty   = 300;
    int unsigned ph = 0;
    logic gen_on = 1'b1;
    logic gen_level = 1'b0;
    logic jit_en = 1'b0;
    logic lvl = 1'b0;
    logic lvl_prev = 1'b0;

    pwm_capture #(.CNT_W(11), .TIMEOUT(2000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (meas_valid === 1'b1) vcnt <= vcnt + 1;

    always @(posedge pwm_in or negedge rst_n) begin
        if (!rst_n) n_rise <= 0;
        else        n_rise <= n_rise + 1;
    end

    initial begin
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            if (gen_on) begin
                if (ph == 0) begin
                    act_period = cfg_period;
                    act_duty   = cfg_duty;
                end
                lvl = (ph < act_duty);
                ph  = (ph + 1 >= act_period) ? 0 : ph + 1;
            end else begin
                ph  = 0;
                lvl = gen_level;
            end
            #1;
            // jitter: an edge may be held back by one clock
            pwm_in   = (jit_en && $urandom_range(0, 1) == 1) ? lvl_prev : lvl;
            lvl_prev = lvl;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " high_cnt"},   high_cnt,   0);
        check({tag, " period_cnt"}, period_cnt, 0);
        check({tag, " meas_valid"}, meas_valid, 0);
        check({tag, " stuck_high"}, stuck_high, 0);
        check({tag, " stuck_low"},  stuck_low,  0);
    endtask

    initial begin
        // reset held while the source already runs 1024 / 300
        repeat (5) @(negedge clk);
        check_zero("reset");
        repeat (512) @(negedge clk);
        rst_n = 1'b1;

        wait_valid("first report", 2100);
        check("first report rises", (n_rise >= 2), 1);
        check("lb high 1", high_cnt, 300);
        check("lb period 1", period_cnt, 1024);
        @(negedge clk);
        check("lb pulse width", meas_valid, 0);
        vstart = vcnt;
        wait_valid("lb report 2", 1100);
        check("lb high 2", high_cnt, 300);
        check("lb period 2", period_cnt, 1024);
        check("lb stuck flags", {stuck_high, stuck_low}, 0);
        repeat (2) @(negedge clk);
        check("lb one pulse per period", vcnt - vstart, 1);

        // asynchronous reset in the middle of a period
        repeat (600) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("mid reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("post reset report", 2100);
        check("post reset rises", (n_rise >= 2), 1);
        check("post reset high", high_cnt, 300);
        check("post reset period", period_cnt, 1024);

        cfg_duty = 1;
        wait_valid("duty1 old", 1100);
        wait_valid("duty1 new", 1100);
        check("duty1 high", high_cnt, 1);
        check("duty1 period", period_cnt, 1024);

        cfg_duty = 1023;
        wait_valid("duty1023 old", 1100);
        wait_valid("duty1023 new", 1100);
        check("duty1023 high", high_cnt, 1023);
        check("duty1023 period", period_cnt, 1024);

        // duty 0: timeout 2000 cycles after the last rise
        cfg_duty = 0;
        wait_valid("stuck low report", 2500);
        check("stuck low flag", stuck_low, 1);
        check("stuck low other flag", stuck_high, 0);
        check("stuck low high", high_cnt, 0);
        check("stuck low period", period_cnt, 0);
        repeat (2) @(negedge clk);
        vstart = vcnt;
        repeat (3000) @(negedge clk);
        check("stuck low no repeat", vcnt - vstart, 0);
        check("stuck low held", stuck_low, 1);

        cfg_duty = 512;
        wait_valid("recover 512 report", 2200);
        check("recover 512 high", high_cnt, 512);
        check("recover 512 period", period_cnt, 1024);
        check("recover stuck low clr", stuck_low, 0);

        // hold high from the current rise
        gen_on = 1'b0;
        gen_level = 1'b1;
        wait_valid("stuck high report", 2500);
        check("stuck high flag", stuck_high, 1);
        check("stuck high other flag", stuck_low, 0);
        check("stuck high high", high_cnt, 0);
        check("stuck high period", period_cnt, 0);
        repeat (2) @(negedge clk);
        vstart = vcnt;
        repeat (1000) @(negedge clk);
        check("stuck high no repeat", vcnt - vstart, 0);

        cfg_period = 30;
        cfg_duty = 10;
        gen_on = 1'b1;
        wait_valid("10/30 report", 200);
        check("10/30 high", high_cnt, 10);
        check("10/30 period", period_cnt, 30);
        check("10/30 stuck high clr", stuck_high, 0);

        // manual rise: sampled at edge k, report registered at edge k+2
        repeat (15) @(negedge clk);
        gen_level = 1'b0;
        gen_on = 1'b0;
        repeat (30) @(negedge clk);
        gen_level = 1'b1;
        repeat (3) @(negedge clk);
        check("latency not early", meas_valid, 0);
        @(negedge clk);
        check("latency on time", meas_valid, 1);
        check("latency high", high_cnt, 10);

        // edges randomly held back one cycle: counts within +/-1
        cfg_period = 100;
        cfg_duty = 40;
        jit_en = 1'b1;
        gen_on = 1'b1;
        wait_valid("jit skip 1", 300);
        wait_valid("jit skip 2", 300);
        for (int k = 0; k < 6; k++) begin
            wait_valid("jit report", 300);
            d = int'(high_cnt) - 40;
            check("jit high range", (d >= -1 && d <= 1), 1);
            d = int'(period_cnt) - 100;
            check("jit period range", (d >= -1 && d <= 1), 1);
        end
        check("jit stuck flags", {stuck_high, stuck_low}, 0);
        jit_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
